cdc_multi_stable: RTL and testbench
===================================

Name: cdc_multi_stable

Overview:
- Destination-domain capture of multi-bit, multi-channel quasi-static buses arriving from an asynchronous source.
- Per bit: a DEST_FF-deep synchronizer. Per channel: a stability filter that updates the output word only after the synchronized word has held constant for C_STABLE_CYC cycles.
- Guarantees no torn or intermediate words reach bdata_out, and gives a one-cycle update strobe per channel.
- Successor to the plain array synchronizer for config/status buses crossing into bclk.

Parameters:
- C_WIDTH, 8: bits per channel.
- C_CH, 2: number of independent channels.
- C_DEST_FF, 3: synchronizer depth per bit; legal range 2..10.
- C_STABLE_CYC, 4: consecutive equal synchronized samples required before update; legal range 1..255.
- C_INIT, 0: reset value of every synchronizer flop and of each channel's output word (C_WIDTH bits, replicated per channel).

Ports:
- bclk  in  1  destination clock; the only clock.
- brst  in  1  synchronous, active-high reset.
- adata_in  in  C_CH*C_WIDTH  asynchronous source data; channel k = bits [k*C_WIDTH +: C_WIDTH].
- bdata_out  out  C_CH*C_WIDTH  filtered, synchronized data per channel.
- bupdate  out  C_CH  one-cycle pulse when the channel's bdata_out word changes.

Behaviour:
- Reset (brst high at a bclk edge): sync flops = C_INIT; prev register p = C_INIT; cnt = 0; bdata_out = C_INIT; bupdate = 0.
- In-flight data is discarded on reset. After release, behaviour is identical to power-up.
- Per channel, let s be the last synchronizer stage output:
  - p <= s every cycle.
  - If s != p: cnt <= 0.
  - Else if cnt < C_STABLE_CYC: cnt <= cnt + 1 (saturating).
  - st = (s == p) and (cnt == C_STABLE_CYC-1).
  - If st and p != bdata_out: bdata_out <= p and bupdate <= 1. Otherwise bupdate <= 0.
- Latency: number input edges from edge 1, the first bclk edge that samples the new stable value.
  - bdata_out and bupdate change on edge C_DEST_FF+C_STABLE_CYC+1.
  - Default parameters: edge 8.
- No update if the new stable value equals the current bdata_out.
- Input toggling with a period at or below the stable window: bdata_out holds its last value indefinitely and no bupdate fires.
- Any bit change within a channel restarts that channel's window. Channels are fully independent; simultaneous updates on several channels are allowed.
- cnt width: clog2(C_STABLE_CYC+1).
- No combinational path from adata_in to any output.
- Every synchronizer flop carries the ASYNC_REG attribute.

Optional Feature:
- Macro: CDC_MULTI_STABLE_UPD_CNT_EN.
- Defined: extra output port bupd_cnt, C_CH*16 bits.
  - Per-channel counter of bupdate pulses, saturating at 16'hFFFF.
  - Cleared by brst.
  - Increments on the same edge that bupdate is asserted.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package cdc_multi_pkg:
  - clog2 function.
  - UPD_CNT_W = 16.
  - Parameter legality ranges: DEST_FF_MIN=2, DEST_FF_MAX=10, STABLE_MAX=255.
- Sub-module cdc_multi_stable_ch: one channel containing synchronizer, prev register, counter, output register and optional update counter.
- Top level is a generate loop of C_CH instances plus port slicing.

Test Plan:
- Reset, then hold adata_in = C_INIT for 20 cycles -> bdata_out = 0 throughout; bupdate never asserts.
- Channel 0 steps 0x00->0xA5 (defaults) -> bdata_out[7:0] = 0xA5 and bupdate[0] = 1 on edge 8 only; channel 1 unchanged with bupdate[1] = 0.
- Channel 1 toggles 0x3C/0xC3 every 3 cycles for 40 cycles, then holds 0xC3 -> no update during toggling; exactly one bupdate[1] pulse 8 edges after the hold begins, with bdata_out[15:8] = 0xC3.
- Both channels change on the same edge (0x11, 0x22) -> both bupdate bits pulse on the same edge 8.
- Assert brst mid-window (edge 5 after a step to 0xFF) -> outputs return to 0 with no pulse; with the input still 0xFF, the update lands 8 edges after release.
- With CDC_MULTI_STABLE_UPD_CNT_EN defined: 3 separate stable changes on channel 0 -> bupd_cnt[15:0] = 3; reset clears it to 0.

Source files
------------

// File: rtl/cdc_multi_pkg.sv
// Shared constants and helpers for the multi-channel stable-capture synchronizer.
package cdc_multi_pkg;

  localparam int unsigned UPD_CNT_W    = 16;
  localparam int unsigned DEST_FF_MIN  = 2;
  localparam int unsigned DEST_FF_MAX  = 10;
  localparam int unsigned STABLE_MAX   = 255;

  // Ceiling log2, usable at elaboration time; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cdc_multi_stable_ch.sv
// One channel: DEST_FF-deep bit synchronizer followed by a stability filter.
// Update counter present only with CDC_MULTI_STABLE_UPD_CNT_EN defined.
module cdc_multi_stable_ch
  import cdc_multi_pkg::*;
#(
  parameter int unsigned  W          = 8,
  parameter int unsigned  DEST_FF    = 3,
  parameter int unsigned  STABLE_CYC = 4,
  parameter logic [W-1:0] INIT       = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [W-1:0]         data_i,
  output logic [W-1:0]         data_o,
  output logic                 update_o
`ifdef CDC_MULTI_STABLE_UPD_CNT_EN
  ,
  output logic [UPD_CNT_W-1:0] upd_cnt_o
`endif
);

  localparam int unsigned      CNT_W    = clog2(STABLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);

  (* ASYNC_REG = "TRUE" *) logic [W-1:0] sync_q [DEST_FF];

  logic [W-1:0]     prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     data_q, data_d;
  logic             upd_q, upd_d;
  logic [W-1:0]     sync_s;
  logic             same;
  logic             stable;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEST_FF); i++) sync_q[i] <= INIT;
    end else begin
      sync_q[0] <= data_i;
      for (int i = 1; i < int'(DEST_FF); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Window restarts on any bit change; output only moves on the exact cycle
  // the window completes, so a torn word can never be committed.
  always_comb begin
    sync_s = sync_q[DEST_FF-1];
    same   = (sync_s == prev_q);
    cnt_d  = cnt_q;
    if (!same)                cnt_d = '0;
    else if (cnt_q < CNT_MAX) cnt_d = cnt_q + 1'b1;
    stable = same && (cnt_q == CNT_LAST);
    data_d = data_q;
    upd_d  = 1'b0;
    if (stable && (prev_q != data_q)) begin
      data_d = prev_q;
      upd_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= INIT;
      cnt_q  <= '0;
      data_q <= INIT;
      upd_q  <= 1'b0;
    end else begin
      prev_q <= sync_s;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      upd_q  <= upd_d;
    end
  end

  assign data_o   = data_q;
  assign update_o = upd_q;

`ifdef CDC_MULTI_STABLE_UPD_CNT_EN
  logic [UPD_CNT_W-1:0] upd_cnt_q, upd_cnt_d;

  always_comb begin
    upd_cnt_d = upd_cnt_q;
    if (upd_d && (upd_cnt_q != '1)) upd_cnt_d = upd_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) upd_cnt_q <= '0;
    else       upd_cnt_q <= upd_cnt_d;
  end

  assign upd_cnt_o = upd_cnt_q;
`endif

endmodule

// File: rtl/cdc_multi_stable.sv
// Multi-channel quasi-static bus capture into bclk; one filtered channel per slice.
// Optional bupd_cnt output enabled by CDC_MULTI_STABLE_UPD_CNT_EN.
module cdc_multi_stable
  import cdc_multi_pkg::*;
#(
  parameter int unsigned        C_WIDTH      = 8,
  parameter int unsigned        C_CH         = 2,
  parameter int unsigned        C_DEST_FF    = 3,
  parameter int unsigned        C_STABLE_CYC = 4,
  parameter logic [C_WIDTH-1:0] C_INIT       = '0
) (
  input  logic                        bclk,
  input  logic                        brst,
  input  logic [C_CH*C_WIDTH-1:0]     adata_in,
  output logic [C_CH*C_WIDTH-1:0]     bdata_out,
  output logic [C_CH-1:0]             bupdate
`ifdef CDC_MULTI_STABLE_UPD_CNT_EN
  ,
  output logic [C_CH*UPD_CNT_W-1:0]   bupd_cnt
`endif
);

  if (C_DEST_FF < DEST_FF_MIN || C_DEST_FF > DEST_FF_MAX) begin : g_bad_dest_ff
    $error("cdc_multi_stable: C_DEST_FF out of range 2..10");
  end
  if (C_STABLE_CYC < 1 || C_STABLE_CYC > STABLE_MAX) begin : g_bad_stable
    $error("cdc_multi_stable: C_STABLE_CYC out of range 1..255");
  end

  for (genvar k = 0; k < int'(C_CH); k++) begin : g_ch
    cdc_multi_stable_ch #(
      .W          (C_WIDTH),
      .DEST_FF    (C_DEST_FF),
      .STABLE_CYC (C_STABLE_CYC),
      .INIT       (C_INIT)
    ) u_ch (
      .clk_i     (bclk),
      .rst_i     (brst),
      .data_i    (adata_in[k*C_WIDTH +: C_WIDTH]),
      .data_o    (bdata_out[k*C_WIDTH +: C_WIDTH]),
      .update_o  (bupdate[k])
`ifdef CDC_MULTI_STABLE_UPD_CNT_EN
      ,
      .upd_cnt_o (bupd_cnt[k*UPD_CNT_W +: UPD_CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_cdc_multi_stable.sv
// Directed bench for cdc_multi_stable at default parameters (2 x 8 bits, 3 FF, window 4).
module tb_cdc_multi_stable;

  localparam int LAT = 8;

  logic        bclk;
  logic        brst;
  logic [15:0] adata_in;
  logic [15:0] bdata_out;
  logic [1:0]  bupdate;
`ifdef CDC_MULTI_STABLE_UPD_CNT_EN
  logic [31:0] bupd_cnt;
`endif

  int checks = 0;
  int errors = 0;

  cdc_multi_stable dut (
    .bclk      (bclk),
    .brst      (brst),
    .adata_in  (adata_in),
    .bdata_out (bdata_out),
    .bupdate   (bupdate)
`ifdef CDC_MULTI_STABLE_UPD_CNT_EN
    ,
    .bupd_cnt  (bupd_cnt)
`endif
  );

  // Clock / reset
  initial bclk = 1'b0;
  always #5 bclk = ~bclk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge bclk);
    #1;
  endtask

  task automatic test_reset();
    brst     = 1'b1;
    adata_in = 16'h0000;
    tick();
    tick();
    checks++;
    if (bdata_out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data got=%h exp=%h", bdata_out, 16'h0000);
    end
    checks++;
    if (bupdate !== 2'b00) begin
      errors++;
      $display("FAIL reset_upd got=%b exp=%b", bupdate, 2'b00);
    end
    brst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++;
      if (bdata_out !== 16'h0000 || bupdate !== 2'b00) begin
        errors++;
        $display("FAIL idle_hold edge=%0d got=%h/%b exp=0000/00", k, bdata_out, bupdate);
      end
    end
  endtask

  task automatic test_ch0_step();
    logic [15:0] exp_d;
    logic [1:0]  exp_u;
    adata_in[7:0] = 8'hA5;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_d = (k >= LAT) ? 16'h00A5 : 16'h0000;
      exp_u = (k == LAT) ? 2'b01 : 2'b00;
      checks++;
      if (bdata_out !== exp_d || bupdate !== exp_u) begin
        errors++;
        $display("FAIL ch0_step edge=%0d got=%h/%b exp=%h/%b", k, bdata_out, bupdate, exp_d, exp_u);
      end
    end
  endtask

  task automatic test_ch1_toggle();
    logic [15:0] exp_d;
    logic [1:0]  exp_u;
    for (int seg = 0; seg < 13; seg++) begin
      adata_in[15:8] = (seg % 2 == 0) ? 8'h3C : 8'hC3;
      for (int j = 0; j < 3; j++) begin
        tick();
        checks++;
        if (bdata_out !== 16'h00A5 || bupdate !== 2'b00) begin
          errors++;
          $display("FAIL toggle_hold seg=%0d got=%h/%b exp=00a5/00", seg, bdata_out, bupdate);
        end
      end
    end
    adata_in[15:8] = 8'hC3;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_d = (k >= LAT) ? 16'hC3A5 : 16'h00A5;
      exp_u = (k == LAT) ? 2'b10 : 2'b00;
      checks++;
      if (bdata_out !== exp_d || bupdate !== exp_u) begin
        errors++;
        $display("FAIL toggle_settle edge=%0d got=%h/%b exp=%h/%b", k, bdata_out, bupdate, exp_d, exp_u);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [15:0] exp_d;
    logic [1:0]  exp_u;
    adata_in = 16'h2211;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_d = (k >= LAT) ? 16'h2211 : 16'hC3A5;
      exp_u = (k == LAT) ? 2'b11 : 2'b00;
      checks++;
      if (bdata_out !== exp_d || bupdate !== exp_u) begin
        errors++;
        $display("FAIL simultaneous edge=%0d got=%h/%b exp=%h/%b", k, bdata_out, bupdate, exp_d, exp_u);
      end
    end
  endtask

  task automatic test_reset_mid_window();
    logic [15:0] exp_d;
    logic [1:0]  exp_u;
    adata_in = 16'h22FF;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (bdata_out !== 16'h2211 || bupdate !== 2'b00) begin
        errors++;
        $display("FAIL pre_reset edge=%0d got=%h/%b exp=2211/00", k, bdata_out, bupdate);
      end
    end
    brst = 1'b1;
    tick();
    checks++;
    if (bdata_out !== 16'h0000 || bupdate !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset got=%h/%b exp=0000/00", bdata_out, bupdate);
    end
    brst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_d = (k >= LAT) ? 16'h22FF : 16'h0000;
      exp_u = (k == LAT) ? 2'b11 : 2'b00;
      checks++;
      if (bdata_out !== exp_d || bupdate !== exp_u) begin
        errors++;
        $display("FAIL post_reset edge=%0d got=%h/%b exp=%h/%b", k, bdata_out, bupdate, exp_d, exp_u);
      end
    end
  endtask

  // A short excursion that returns to the committed value must not pulse.
  task automatic test_glitch_same_value();
    adata_in[7:0] = 8'h5A;
    tick();
    tick();
    adata_in[7:0] = 8'hFF;
    for (int k = 1; k <= 15; k++) begin
      tick();
      checks++;
      if (bdata_out !== 16'h22FF || bupdate !== 2'b00) begin
        errors++;
        $display("FAIL glitch edge=%0d got=%h/%b exp=22ff/00", k, bdata_out, bupdate);
      end
    end
  endtask

`ifdef CDC_MULTI_STABLE_UPD_CNT_EN
  task automatic test_upd_cnt();
    logic [7:0] vals [3];
    vals[0] = 8'h01;
    vals[1] = 8'h02;
    vals[2] = 8'h03;
    adata_in = 16'h0000;
    brst     = 1'b1;
    tick();
    brst = 1'b0;
    checks++;
    if (bupd_cnt !== 32'h0) begin
      errors++;
      $display("FAIL upd_cnt_reset got=%h exp=%h", bupd_cnt, 32'h0);
    end
    for (int i = 0; i < 3; i++) begin
      adata_in[7:0] = vals[i];
      for (int k = 1; k <= 10; k++) tick();
      checks++;
      if (bupd_cnt !== {16'h0, 16'(i + 1)}) begin
        errors++;
        $display("FAIL upd_cnt step=%0d got=%h exp=%h", i, bupd_cnt, {16'h0, 16'(i + 1)});
      end
    end
    brst = 1'b1;
    tick();
    brst = 1'b0;
    checks++;
    if (bupd_cnt !== 32'h0) begin
      errors++;
      $display("FAIL upd_cnt_clear got=%h exp=%h", bupd_cnt, 32'h0);
    end
  endtask
`endif

  initial begin
    brst     = 1'b1;
    adata_in = 16'h0000;
    test_reset();
    test_ch0_step();
    test_ch1_toggle();
    test_simultaneous();
    test_reset_mid_window();
    test_glitch_same_value();
`ifdef CDC_MULTI_STABLE_UPD_CNT_EN
    test_upd_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
